chaos_iter_ctrl: RTL and testbench
==================================

// Module: chaos_iter_ctrl
// PURPOSE
//  Iteration sequencer directly upstream of the chaotic-equation-set block.
//  - Holds the current state (x,y,z) and issues one n_valid per iteration.
//  - Waits for n1_valid, then feeds the returned xn1/yn1/zn1 back as the next state.
//  - Discards the first DISCARD transient iterations.
//  - Streams the remaining states to the downstream M-sequence quantiser over a valid/ready handshake.
// PARAMETERS
//  DATA_WIDTH      64    width of each state word; must match the equation block and float IP
//  CNT_WIDTH       32    width of the iteration, sample and watchdog counters
//  DISCARD         1000  number of transient iterations dropped after every start
//  TIMEOUT_CYCLES  4096  watchdog limit on WAIT cycles; used only with CHAOS_TIMEOUT_EN
// PORTS
//  clk          in   1           system clock; all logic rises on posedge
//  rst_n        in   1           asynchronous active-low reset
//  start        in   1           1-cycle pulse; loads x0/y0/z0 and begins a run (honoured only when busy=0)
//  stop         in   1           synchronous abort; state -> IDLE on the next edge
//  num_samples  in   CNT_WIDTH   samples per run, sampled at start; 0 = run until stop
//  x0,y0,z0     in   DATA_WIDTH  initial condition, sampled at start
//  n_valid      out  1           to equation block; 1-cycle request pulse
//  xn,yn,zn     out  DATA_WIDTH  to equation block; current state registers
//  n1_valid     in   1           from equation block; result strobe
//  xn1,yn1,zn1  in   DATA_WIDTH  from equation block; next state
//  out_valid    out  1           sample available
//  out_ready    in   1           consumer accepts the sample when out_valid&&out_ready
//  out_x,out_y,out_z out DATA_WIDTH  sample data, equal to xn/yn/zn while out_valid=1
//  busy         out  1           (state!=IDLE) || inflight
//  done         out  1           1-cycle pulse after the last sample of a finite run is accepted
//  err          out  1           sticky watchdog flag, cleared by the next accepted start
// BEHAVIOUR
//  Reset: all outputs 0; state registers 0; counters 0; inflight 0; state = IDLE.
//  FSM states: IDLE, ISSUE, WAIT, EMIT.
//  - IDLE: a start with busy=0 latches x0/y0/z0 and num_samples, clears iter_cnt and smp_cnt, clears err -> ISSUE.
//  - ISSUE: n_valid=1 for exactly one cycle; inflight<=1 -> WAIT.
//  - WAIT: on n1_valid, capture xn1/yn1/zn1 into the state registers, clear inflight, iter_cnt++.
//    Then go to ISSUE if iter_cnt (post-increment) <= DISCARD, otherwise to EMIT.
//  - EMIT: out_valid=1 with data held stable until accepted. On acceptance smp_cnt++.
//    If num_samples!=0 and smp_cnt==num_samples-1: pulse done, go to IDLE. Otherwise go to ISSUE.
//  Latency:
//  - start -> first n_valid is 2 cycles.
//  - n1_valid -> next n_valid is 2 cycles (via ISSUE).
//  - n1_valid -> out_valid is 1 cycle.
//  Exactly one request is outstanding at any time; the equation block is not pipelined.
//  Boundaries:
//  - DISCARD=0: the first result is emitted directly.
//  - iter_cnt saturates at all-ones and never wraps back into the discard window.
//  - smp_cnt wraps freely when num_samples=0.
//  - n1_valid seen outside WAIT: if inflight=1 it only clears inflight (stale result after stop); otherwise it is ignored.
//  - start while busy=1 (including IDLE with inflight=1) is ignored, so a stale result never corrupts a new run.
//  - start and stop in the same cycle: stop wins; start is ignored.
//  - stop in EMIT drops the sample: out_valid falls on the next edge and done does not pulse.
//  - Reset mid-run returns to reset values immediately.
// CONFIGURATION
//  Macro CHAOS_TIMEOUT_EN.
//  - Defined: a watchdog counts WAIT cycles. When the count reaches TIMEOUT_CYCLES, err<=1, go to IDLE, and inflight stays 1 until n1_valid arrives.
//  - Undefined: WAIT holds indefinitely; err is tied to 0; TIMEOUT_CYCLES is unused.
// STRUCTURE
//  - Package chaos_pkg: state enum (IDLE/ISSUE/WAIT/EMIT), default DATA_WIDTH and CNT_WIDTH localparams, and a struct holding the x/y/z triple.
//  - Sub-module chaos_watchdog (counter + compare, CNT_WIDTH), instantiated only under CHAOS_TIMEOUT_EN.
// TESTING
//  All tests use a stub equation block with a fixed 5-cycle latency that returns xn+1, yn+2 and zn+3 (integer add).
//  T1: DISCARD=2, num_samples=3, x0=0,y0=0,z0=0, out_ready=1.
//      -> samples (3,6,9), (4,8,12), (5,10,15); done pulses once; 5 n_valid pulses total.
//  T2: out_ready=0 for 10 cycles during EMIT.
//      -> out_x/out_y/out_z stable, no n_valid issued, then the run proceeds.
//  T3: stop asserted 2 cycles after an n_valid, then start 1 cycle later.
//      -> start ignored (busy=1 until the stale n1_valid); a second start afterwards loads fresh x0.
//  T4: num_samples=0, DISCARD=0.
//      -> 20 consecutive samples, no done; stop then returns busy to 0.
//  T5 (CHAOS_TIMEOUT_EN): stub never answers, TIMEOUT_CYCLES=16.
//      -> err=1 within 17 cycles of WAIT entry, state IDLE; the next accepted start clears err.
//  T6: rst_n pulsed low while in WAIT.
//      -> all outputs 0 asynchronously; a post-reset start runs T1 correctly.

Source files
------------

// File: rtl/chaos_pkg.sv
// chaos_pkg: shared types and defaults for the chaotic iteration sequencer.
// Holds the FSM state encoding, default widths and the x/y/z triple type.
package chaos_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_CNT_WIDTH  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_EMIT  = 2'd3
    } state_e;

    // One point of the attractor at the default word width.
    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] x;
        logic [DEF_DATA_WIDTH-1:0] y;
        logic [DEF_DATA_WIDTH-1:0] z;
    } triple_t;

endpackage

// File: rtl/chaos_watchdog.sv
// chaos_watchdog: counts consecutive cycles with en_i high and flags the
// cycle in which the count reaches LIMIT. Only instantiated by
// chaos_iter_ctrl when CHAOS_TIMEOUT_EN is defined.
module chaos_watchdog
    import chaos_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int LIMIT     = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CNT_WIDTH-1:0] LIMIT_C = CNT_WIDTH'(LIMIT);

    logic [CNT_WIDTH-1:0] cnt_q;

    // Count while enabled, restart from zero whenever the enable drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    // cnt_q holds the number of enabled cycles already completed, so the
    // LIMIT-th enabled cycle is the one that sees LIMIT-1.
    assign expired_o = en_i && (cnt_q == LIMIT_C - 1'b1);

endmodule

// File: rtl/chaos_iter_ctrl.sv
// chaos_iter_ctrl: iteration sequencer upstream of the chaotic equation block.
// Issues one request per iteration, feeds results back as the next state,
// drops the first DISCARD iterations and streams the rest downstream.
// Define CHAOS_TIMEOUT_EN to add a watchdog on the WAIT state (sets err).
module chaos_iter_ctrl
    import chaos_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int DISCARD        = 1000,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [CNT_WIDTH-1:0]  num_samples,
    input  logic [DATA_WIDTH-1:0] x0,
    input  logic [DATA_WIDTH-1:0] y0,
    input  logic [DATA_WIDTH-1:0] z0,
    output logic                  n_valid,
    output logic [DATA_WIDTH-1:0] xn,
    output logic [DATA_WIDTH-1:0] yn,
    output logic [DATA_WIDTH-1:0] zn,
    input  logic                  n1_valid,
    input  logic [DATA_WIDTH-1:0] xn1,
    input  logic [DATA_WIDTH-1:0] yn1,
    input  logic [DATA_WIDTH-1:0] zn1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_x,
    output logic [DATA_WIDTH-1:0] out_y,
    output logic [DATA_WIDTH-1:0] out_z,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] x;
        logic [DATA_WIDTH-1:0] y;
        logic [DATA_WIDTH-1:0] z;
    } vec_t;

    localparam logic [CNT_WIDTH-1:0] DISCARD_C = CNT_WIDTH'(DISCARD);

    state_e               state_q, state_d;
    vec_t                 cur_q, cur_d;
    logic                 inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0] iter_cnt_q, iter_cnt_d;
    logic [CNT_WIDTH-1:0] smp_cnt_q, smp_cnt_d;
    logic [CNT_WIDTH-1:0] nsamp_q, nsamp_d;
    logic                 n_valid_q, n_valid_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                 timeout;
    logic [CNT_WIDTH-1:0] iter_inc;
    logic                 last_smp;

`ifdef CHAOS_TIMEOUT_EN
    chaos_watchdog #(
        .CNT_WIDTH (CNT_WIDTH),
        .LIMIT     (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (state_q == ST_WAIT),
        .expired_o (timeout)
    );
`else
    // Without the watchdog WAIT holds forever and err never rises.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    // Saturate so a very long run never wraps back into the discard window.
    assign iter_inc = (iter_cnt_q == '1) ? iter_cnt_q : iter_cnt_q + 1'b1;
    assign last_smp = (nsamp_q != '0) && (smp_cnt_q == nsamp_q - 1'b1);
    assign busy     = (state_q != ST_IDLE) || inflight_q;

    // Next-state logic for the ISSUE/WAIT/EMIT iteration loop.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        cur_d      = cur_q;
        inflight_d = inflight_q;
        iter_cnt_d = iter_cnt_q;
        smp_cnt_d  = smp_cnt_q;
        nsamp_d    = nsamp_q;
        n_valid_d  = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;

        // Any returning result retires the single outstanding request; a
        // result arriving outside WAIT is stale and carries no state update.
        if (n1_valid) begin
            inflight_d = 1'b0;
        end

        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !busy) begin
                        cur_d      = '{x: x0, y: y0, z: z0};
                        nsamp_d    = num_samples;
                        iter_cnt_d = '0;
                        smp_cnt_d  = '0;
                        err_d      = 1'b0;
                        state_d    = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    n_valid_d  = 1'b1;
                    inflight_d = 1'b1;
                    state_d    = ST_WAIT;
                end
                ST_WAIT: begin
                    if (n1_valid) begin
                        cur_d      = '{x: xn1, y: yn1, z: zn1};
                        iter_cnt_d = iter_inc;
                        state_d    = (iter_inc > DISCARD_C) ? ST_EMIT : ST_ISSUE;
                    end else if (timeout) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        smp_cnt_d = smp_cnt_q + 1'b1;
                        if (last_smp) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_ISSUE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Register the FSM, datapath state, counters and output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values and updates together.
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            inflight_q <= 1'b0;
            iter_cnt_q <= '0;
            smp_cnt_q  <= '0;
            nsamp_q    <= '0;
            n_valid_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            inflight_q <= inflight_d;
            iter_cnt_q <= iter_cnt_d;
            smp_cnt_q  <= smp_cnt_d;
            nsamp_q    <= nsamp_d;
            n_valid_q  <= n_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign n_valid   = n_valid_q;
    assign xn        = cur_q.x;
    assign yn        = cur_q.y;
    assign zn        = cur_q.z;
    assign out_valid = (state_q == ST_EMIT);
    assign out_x     = cur_q.x;
    assign out_y     = cur_q.y;
    assign out_z     = cur_q.z;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_chaos_iter_ctrl.sv
// tb_chaos_iter_ctrl: self-checking bench for chaos_iter_ctrl.
// Two instances (DISCARD=2 and DISCARD=0), each answered by a stub equation
// block returning x+1, y+2, z+3 after a fixed delay. Expected samples come
// from the closed form: sample k = initial + step * (DISCARD + 1 + k).
module tb_chaos_iter_ctrl;
    import chaos_pkg::*;

    localparam int DW = DEF_DATA_WIDTH;
    localparam int CW = DEF_CNT_WIDTH;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          start [2];
    logic          stop [2];
    logic          out_ready [2];
    logic [CW-1:0] num_samples [2];
    logic [DW-1:0] x0 [2], y0 [2], z0 [2];
    logic          n_valid [2], n1_valid [2], out_valid [2];
    logic          busy [2], done [2], err [2];
    logic [DW-1:0] xn [2], yn [2], zn [2];
    logic [DW-1:0] xn1 [2], yn1 [2], zn1 [2];
    logic [DW-1:0] out_x [2], out_y [2], out_z [2];
    logic          stub_mute [2];
    int            stub_cnt [2];
    int            nv_cnt [2];
    int            done_cnt [2];

    int compared   = 0;
    int mismatched = 0;

    chaos_iter_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .DISCARD(2), .TIMEOUT_CYCLES(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .stop(stop[0]), .num_samples(num_samples[0]),
        .x0(x0[0]), .y0(y0[0]), .z0(z0[0]), .n_valid(n_valid[0]), .xn(xn[0]), .yn(yn[0]), .zn(zn[0]),
        .n1_valid(n1_valid[0]), .xn1(xn1[0]), .yn1(yn1[0]), .zn1(zn1[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_x(out_x[0]), .out_y(out_y[0]),
        .out_z(out_z[0]), .busy(busy[0]), .done(done[0]), .err(err[0]));

    chaos_iter_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .DISCARD(0), .TIMEOUT_CYCLES(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .stop(stop[1]), .num_samples(num_samples[1]),
        .x0(x0[1]), .y0(y0[1]), .z0(z0[1]), .n_valid(n_valid[1]), .xn(xn[1]), .yn(yn[1]), .zn(zn[1]),
        .n1_valid(n1_valid[1]), .xn1(xn1[1]), .yn1(yn1[1]), .zn1(zn1[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_x(out_x[1]), .out_y(out_y[1]),
        .out_z(out_z[1]), .busy(busy[1]), .done(done[1]), .err(err[1]));

    // Stub equation blocks and request/done monitors, one per instance.
    for (genvar g = 0; g < 2; g++) begin : g_stub
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stub_cnt[g] <= 0;
                n1_valid[g] <= 1'b0;
                xn1[g]      <= '0;
                yn1[g]      <= '0;
                zn1[g]      <= '0;
            end else begin
                n1_valid[g] <= 1'b0;
                if (n_valid[g]) begin
                    stub_cnt[g] <= 5;
                    xn1[g]      <= xn[g] + 64'd1;
                    yn1[g]      <= yn[g] + 64'd2;
                    zn1[g]      <= zn[g] + 64'd3;
                end else if (stub_cnt[g] != 0 && !stub_mute[g]) begin
                    stub_cnt[g] <= stub_cnt[g] - 1;
                    if (stub_cnt[g] == 1) n1_valid[g] <= 1'b1;
                end
            end
        end

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                nv_cnt[g]   <= 0;
                done_cnt[g] <= 0;
            end else begin
                if (n_valid[g]) nv_cnt[g] <= nv_cnt[g] + 1;
                if (done[g])    done_cnt[g] <= done_cnt[g] + 1;
            end
        end
    end

    function automatic int disc_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic logic [DW-1:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic triple_t rand_triple();
        triple_t t;
        t.x = rand64();
        t.y = rand64();
        t.z = rand64();
        return t;
    endfunction

    // Reference model: k-th emitted sample after DISCARD dropped iterations.
    function automatic triple_t expect_sample(input triple_t init, input int discard, input int k);
        triple_t r;
        logic [DW-1:0] n;
        n   = DW'(discard + k + 1);
        r.x = init.x + n;
        r.y = init.y + 2 * n;
        r.z = init.z + 3 * n;
        return r;
    endfunction

    task automatic start_run(input int d, input int ns, input triple_t init);
        @(negedge clk);
        start[d]       = 1'b1;
        num_samples[d] = CW'(ns);
        x0[d]          = init.x;
        y0[d]          = init.y;
        z0[d]          = init.z;
        @(negedge clk);
        start[d] = 1'b0;
    endtask

    task automatic wait_nvalid(input int d, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (n_valid[d] === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(input int d, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (busy[d] === 1'b0) ok = 1'b1;
        end
    endtask

    // Collects one accepted sample; 'stable' drops if a stalled sample moved.
    task automatic wait_sample(input int d, input bit rnd_ready, input int budget,
                               output triple_t s, output bit got, output bit stable);
        bit      held = 1'b0;
        triple_t h    = '0;
        got    = 1'b0;
        stable = 1'b1;
        s      = '0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (held && (out_valid[d] !== 1'b1 || out_x[d] !== h.x || out_y[d] !== h.y || out_z[d] !== h.z))
                stable = 1'b0;
            out_ready[d] = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid[d] === 1'b1) begin
                if (out_ready[d]) begin
                    got = 1'b1;
                    s   = '{x: out_x[d], y: out_y[d], z: out_z[d]};
                end else begin
                    held = 1'b1;
                    h    = '{x: out_x[d], y: out_y[d], z: out_z[d]};
                end
            end
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            compared++;
            if ({n_valid[d], out_valid[d], busy[d], done[d], err[d]} !== 5'b0) begin
                mismatched++;
                $display("FAIL reset_flags[%0d]: got %b expected 00000", d,
                         {n_valid[d], out_valid[d], busy[d], done[d], err[d]});
            end
            compared++;
            if ({xn[d], yn[d], zn[d], out_x[d], out_y[d], out_z[d]} !== '0) begin
                mismatched++;
                $display("FAIL reset_data[%0d]: got xn=%h out_x=%h expected 0", d, xn[d], out_x[d]);
            end
        end
    endtask

    // DISCARD=2, three samples from the origin, full-rate consumer.
    task automatic test_basic();
        triple_t init = '0;
        triple_t s;
        bit got, stab, ok;
        int nv0 = nv_cnt[0];
        int dc0 = done_cnt[0];
        out_ready[0] = 1'b1;
        start_run(0, 3, init);
        compared++;
        if (n_valid[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL start_latency_early: got n_valid=%b expected 0", n_valid[0]);
        end
        @(negedge clk);
        compared++;
        if (n_valid[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL start_latency: got n_valid=%b expected 1", n_valid[0]);
        end
        for (int k = 0; k < 3; k++) begin
            wait_sample(0, 1'b0, 100, s, got, stab);
            compared++;
            if (!got || s !== expect_sample(init, 2, k)) begin
                mismatched++;
                $display("FAIL basic_sample[%0d]: got %h (seen=%0d) expected %h", k, s, got, expect_sample(init, 2, k));
            end
        end
        wait_idle(0, 50, ok);
        repeat (2) @(negedge clk);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL basic_idle: busy still %b expected 0", busy[0]);
        end
        compared++;
        if (nv_cnt[0] - nv0 != 5 || done_cnt[0] - dc0 != 1) begin
            mismatched++;
            $display("FAIL basic_counts: got n_valid=%0d done=%0d expected 5 and 1", nv_cnt[0] - nv0, done_cnt[0] - dc0);
        end
    endtask

    // Consumer stalls 10 cycles on the first sample of a two-sample run.
    task automatic test_backpressure();
        triple_t init = rand_triple();
        triple_t s, first;
        bit got, stab, ok;
        int nv0;
        int dc0 = done_cnt[0];
        out_ready[0] = 1'b0;
        start_run(0, 2, init);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (out_valid[0] === 1'b1) ok = 1'b1;
        end
        first = '{x: out_x[0], y: out_y[0], z: out_z[0]};
        nv0   = nv_cnt[0];
        compared++;
        if (!ok || first !== expect_sample(init, 2, 0)) begin
            mismatched++;
            $display("FAIL bp_first: got %h (seen=%0d) expected %h", first, ok, expect_sample(init, 2, 0));
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            compared++;
            if (out_valid[0] !== 1'b1 || out_x[0] !== first.x || out_y[0] !== first.y || out_z[0] !== first.z) begin
                mismatched++;
                $display("FAIL bp_hold[%0d]: got valid=%b x=%h expected valid=1 x=%h", i, out_valid[0], out_x[0], first.x);
            end
        end
        compared++;
        if (nv_cnt[0] != nv0) begin
            mismatched++;
            $display("FAIL bp_no_issue: got %0d requests during stall expected 0", nv_cnt[0] - nv0);
        end
        for (int k = 0; k < 2; k++) begin
            wait_sample(0, 1'b0, 100, s, got, stab);
            compared++;
            if (!got || s !== expect_sample(init, 2, k)) begin
                mismatched++;
                $display("FAIL bp_sample[%0d]: got %h (seen=%0d) expected %h", k, s, got, expect_sample(init, 2, k));
            end
        end
        wait_idle(0, 50, ok);
        repeat (2) @(negedge clk);
        compared++;
        if (!ok || done_cnt[0] - dc0 != 1) begin
            mismatched++;
            $display("FAIL bp_done: got idle=%0d done=%0d expected 1 and 1", ok, done_cnt[0] - dc0);
        end
    endtask

    // Stop mid-WAIT, start while the stale result is pending, then restart.
    task automatic test_stop_stale();
        triple_t init_a = rand_triple();
        triple_t init_b = rand_triple();
        triple_t init_c = rand_triple();
        triple_t hold, s;
        bit ok, got, stab;
        int nv0, dc0;
        out_ready[0] = 1'b1;
        start_run(0, 0, init_a);
        wait_nvalid(0, 20, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL stale_first_req: no n_valid seen expected one");
        end
        @(negedge clk);
        @(negedge clk);
        stop[0] = 1'b1;
        hold    = '{x: xn[0], y: yn[0], z: zn[0]};
        nv0     = nv_cnt[0];
        @(negedge clk);
        stop[0]        = 1'b0;
        start[0]       = 1'b1;
        num_samples[0] = 1;
        x0[0]          = init_b.x;
        y0[0]          = init_b.y;
        z0[0]          = init_b.z;
        @(negedge clk);
        start[0] = 1'b0;
        compared++;
        if (busy[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL stale_busy: got busy=%b expected 1", busy[0]);
        end
        wait_idle(0, 30, ok);
        repeat (2) @(negedge clk);
        compared++;
        if (!ok || nv_cnt[0] != nv0) begin
            mismatched++;
            $display("FAIL stale_ignored_start: got idle=%0d requests=%0d expected 1 and 0", ok, nv_cnt[0] - nv0);
        end
        compared++;
        if ({xn[0], yn[0], zn[0]} !== hold) begin
            mismatched++;
            $display("FAIL stale_state: got %h expected %h", {xn[0], yn[0], zn[0]}, hold);
        end
        dc0 = done_cnt[0];
        start_run(0, 1, init_c);
        wait_sample(0, 1'b0, 100, s, got, stab);
        compared++;
        if (!got || s !== expect_sample(init_c, 2, 0)) begin
            mismatched++;
            $display("FAIL stale_restart: got %h (seen=%0d) expected %h", s, got, expect_sample(init_c, 2, 0));
        end
        wait_idle(0, 50, ok);
        repeat (2) @(negedge clk);
        compared++;
        if (!ok || done_cnt[0] - dc0 != 1) begin
            mismatched++;
            $display("FAIL stale_restart_done: got idle=%0d done=%0d expected 1 and 1", ok, done_cnt[0] - dc0);
        end
        // start and stop together: stop wins and nothing is launched
        nv0 = nv_cnt[0];
        @(negedge clk);
        start[0] = 1'b1;
        stop[0]  = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        stop[0]  = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if (busy[0] !== 1'b0 || nv_cnt[0] != nv0) begin
            mismatched++;
            $display("FAIL start_stop_same: got busy=%b requests=%0d expected 0 and 0", busy[0], nv_cnt[0] - nv0);
        end
    endtask

    // DISCARD=0, unbounded run: 20 samples, then stop in EMIT drops the sample.
    task automatic test_free_run();
        triple_t init = rand_triple();
        triple_t s;
        bit ok, got, stab;
        int dc0 = done_cnt[1];
        out_ready[1] = 1'b0;
        start_run(1, 0, init);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (n1_valid[1] === 1'b1) ok = 1'b1;
        end
        compared++;
        if (!ok || out_valid[1] !== 1'b0) begin
            mismatched++;
            $display("FAIL free_first_result: got seen=%0d out_valid=%b expected 1 and 0", ok, out_valid[1]);
        end
        @(negedge clk);
        compared++;
        if (out_valid[1] !== 1'b1) begin
            mismatched++;
            $display("FAIL free_out_latency: got out_valid=%b expected 1", out_valid[1]);
        end
        for (int k = 0; k < 20; k++) begin
            wait_sample(1, 1'b0, 100, s, got, stab);
            compared++;
            if (!got || s !== expect_sample(init, 0, k)) begin
                mismatched++;
                $display("FAIL free_sample[%0d]: got %h (seen=%0d) expected %h", k, s, got, expect_sample(init, 0, k));
            end
        end
        @(negedge clk);
        out_ready[1] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (out_valid[1] === 1'b1) ok = 1'b1;
        end
        stop[1] = 1'b1;
        @(negedge clk);
        stop[1] = 1'b0;
        compared++;
        if (!ok || out_valid[1] !== 1'b0 || busy[1] !== 1'b0) begin
            mismatched++;
            $display("FAIL free_stop_emit: got seen=%0d out_valid=%b busy=%b expected 1 0 0", ok, out_valid[1], busy[1]);
        end
        repeat (3) @(negedge clk);
        compared++;
        if (done_cnt[1] != dc0) begin
            mismatched++;
            $display("FAIL free_no_done: got %0d done pulses expected 0", done_cnt[1] - dc0);
        end
    endtask

    // Random instance, length, initial point and consumer readiness.
    task automatic test_random();
        triple_t init, s;
        bit ok, got, stab;
        int d, ns, nv0, dc0;
        for (int r = 0; r < 6; r++) begin
            d    = $urandom_range(0, 1);
            ns   = $urandom_range(1, 4);
            init = rand_triple();
            nv0  = nv_cnt[d];
            dc0  = done_cnt[d];
            start_run(d, ns, init);
            for (int k = 0; k < ns; k++) begin
                wait_sample(d, 1'b1, 200, s, got, stab);
                compared++;
                if (!got || !stab || s !== expect_sample(init, disc_of(d), k)) begin
                    mismatched++;
                    $display("FAIL rand_sample[%0d.%0d]: got %h (seen=%0d stable=%0d) expected %h",
                             r, k, s, got, stab, expect_sample(init, disc_of(d), k));
                end
            end
            wait_idle(d, 50, ok);
            repeat (2) @(negedge clk);
            compared++;
            if (!ok || nv_cnt[d] - nv0 != disc_of(d) + ns || done_cnt[d] - dc0 != 1) begin
                mismatched++;
                $display("FAIL rand_counts[%0d]: got idle=%0d requests=%0d done=%0d expected 1 %0d 1",
                         r, ok, nv_cnt[d] - nv0, done_cnt[d] - dc0, disc_of(d) + ns);
            end
        end
    endtask

`ifdef CHAOS_TIMEOUT_EN
    // Silent equation block: watchdog must fire, then a new start clears err.
    task automatic test_timeout();
        triple_t init = rand_triple();
        triple_t s;
        bit ok, got, stab;
        int waited = 0;
        stub_mute[0] = 1'b1;
        out_ready[0] = 1'b1;
        start_run(0, 1, init);
        wait_nvalid(0, 20, ok);
        for (int i = 1; i <= 17 && err[0] !== 1'b1; i++) begin
            @(negedge clk);
            waited = i;
        end
        compared++;
        if (!ok || err[0] !== 1'b1 || busy[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL timeout_err: got err=%b busy=%b after %0d cycles expected err=1 busy=1", err[0], busy[0], waited);
        end
        stub_mute[0] = 1'b0;
        wait_idle(0, 30, ok);
        start_run(0, 1, init);
        compared++;
        if (!ok || err[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL timeout_clear: got idle=%0d err=%b expected 1 and 0", ok, err[0]);
        end
        wait_sample(0, 1'b0, 100, s, got, stab);
        compared++;
        if (!got || s !== expect_sample(init, 2, 0)) begin
            mismatched++;
            $display("FAIL timeout_rerun: got %h expected %h", s, expect_sample(init, 2, 0));
        end
        wait_idle(0, 50, ok);
    endtask
`endif

    // Asynchronous reset while waiting on the equation block, then rerun T1.
    task automatic test_reset_midrun();
        bit ok;
        out_ready[0] = 1'b1;
        start_run(0, 3, rand_triple());
        wait_nvalid(0, 20, ok);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_basic();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start[d]       = 1'b0;
            stop[d]        = 1'b0;
            out_ready[d]   = 1'b0;
            num_samples[d] = '0;
            x0[d]          = '0;
            y0[d]          = '0;
            z0[d]          = '0;
            stub_mute[d]   = 1'b0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_backpressure();
        test_stop_stale();
        test_free_run();
        test_random();
`ifdef CHAOS_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
